// File: rtl/kf_bus_arbiter_pkg.sv
// Shared types and constants for the KF bus arbiter: FSM states, the control
// bundle sent to the bus controller, and the state-to-outputs decode.
package kf_bus_arbiter_pkg;

    localparam int CNT_W  = 4;
    localparam int HOLD_W = 16;

    localparam logic [2:0] PASSIVE_STATUS = 3'b111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        SETTLE    = 3'd2,
        GRANT     = 3'd3,
        RELEASE   = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic hlda;
        logic aen_n;
        logic cen;
        logic rdy;
    } arb_ctl_t;

    // The CPU side keeps the bus in IDLE and WAIT_IDLE. It is floated whenever
    // the DMA owns the bus or is taking it over.
    function automatic arb_ctl_t decode_ctl(input arb_state_t st);
        arb_ctl_t ctl;
        ctl = '{hlda: 1'b0, aen_n: 1'b1, cen: 1'b1, rdy: 1'b1};
        unique case (st)
            SETTLE, RELEASE: ctl = '{hlda: 1'b0, aen_n: 1'b0, cen: 1'b0, rdy: 1'b0};
            GRANT:           ctl = '{hlda: 1'b1, aen_n: 1'b0, cen: 1'b0, rdy: 1'b0};
            default:         ctl = '{hlda: 1'b0, aen_n: 1'b1, cen: 1'b1, rdy: 1'b1};
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/kf_clock_edge_detect.sv
// Edge detector for a slow clock that is sampled as data on the fast clock.
// Each output is a single-cycle pulse in the fast clock domain.
module kf_clock_edge_detect (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic signal_i,
    output logic posedge_o,
    output logic negedge_o
);

    logic prev_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= signal_i;
        end
    end

    assign posedge_o = ~prev_q & signal_i;
    assign negedge_o = prev_q & ~signal_i;

endmodule

// File: rtl/kf_bus_arbiter.sv
// Hands the system bus between the CPU (through the bus controller) and the DMA.
// Optional hold watchdog is enabled by defining KF_BUS_ARBITER_WATCHDOG_EN.
module kf_bus_arbiter
    import kf_bus_arbiter_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 2,
    parameter int RELEASE_CYCLES  = 1,
    parameter int MAX_HOLD_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_clock,
    input  logic [2:0] processor_status,
    input  logic       lock_n,
    input  logic       hold_request,
    output logic       hold_acknowledge,
    output logic       address_enable_n,
    output logic       command_enable,
    output logic       cpu_ready,
    output logic       timeout
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || RELEASE_CYCLES < 1 || RELEASE_CYCLES > 15 ||
        MAX_HOLD_CYCLES < 1 || MAX_HOLD_CYCLES > 65535) begin : g_bad_param
        $error("kf_bus_arbiter: parameter out of range");
    end

    localparam logic [CNT_W-1:0] SETTLE_INIT  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_INIT = CNT_W'(RELEASE_CYCLES - 1);

    logic       cpu_pos;
    arb_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arb_ctl_t   ctl_q;
    logic       rearm_ok;

    kf_clock_edge_detect u_cpu_clock_edge (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .signal_i  (cpu_clock),
        .posedge_o (cpu_pos),
        .negedge_o ()
    );

`ifdef KF_BUS_ARBITER_WATCHDOG_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic              block_q, block_d;

    // After a watchdog release the requester must drop HRQ once before it can win again.
    assign rearm_ok = ~block_q;
    assign timeout  = timeout_q;
`else
    assign rearm_ok = 1'b1;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef KF_BUS_ARBITER_WATCHDOG_EN
        hold_d    = hold_q;
        timeout_d = timeout_q;
        block_d   = block_q;
        if (cpu_pos && !hold_request) begin
            block_d = 1'b0;
        end
`endif
        if (cpu_pos) begin
            unique case (state_q)
                IDLE: begin
                    if (hold_request && rearm_ok) begin
                        state_d = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!hold_request) begin
                        state_d = IDLE;
                    end else if (processor_status == PASSIVE_STATUS && lock_n) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_INIT;
                    end
                end
                SETTLE: begin
                    if (!hold_request) begin
                        state_d = RELEASE;
                        cnt_d   = RELEASE_INIT;
                    end else if (cnt_q == '0) begin
                        state_d = GRANT;
`ifdef KF_BUS_ARBITER_WATCHDOG_EN
                        hold_d    = '0;
                        timeout_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GRANT: begin
                    if (!hold_request) begin
                        state_d = RELEASE;
                        cnt_d   = RELEASE_INIT;
`ifdef KF_BUS_ARBITER_WATCHDOG_EN
                    end else if (hold_q == HOLD_LAST) begin
                        state_d   = RELEASE;
                        cnt_d     = RELEASE_INIT;
                        timeout_d = 1'b1;
                        block_d   = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they move on the same edge as the FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= decode_ctl(IDLE);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= decode_ctl(state_d);
        end
    end

`ifdef KF_BUS_ARBITER_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
            block_q   <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            block_q   <= block_d;
        end
    end
`endif

    assign hold_acknowledge = ctl_q.hlda;
    assign address_enable_n = ctl_q.aen_n;
    assign command_enable   = ctl_q.cen;
    assign cpu_ready        = ctl_q.rdy;

endmodule

// File: tb/tb_kf_bus_arbiter.sv
// Directed self-checking bench for kf_bus_arbiter; the watchdog section runs
// only when KF_BUS_ARBITER_WATCHDOG_EN is defined (MAX_HOLD_CYCLES=8).
module tb_kf_bus_arbiter;

`ifdef KF_BUS_ARBITER_WATCHDOG_EN
    localparam int MAXH = 8;
`else
    localparam int MAXH = 255;
`endif

    // {hlda, aen_n, cen, rdy} per arbiter state
    localparam logic [3:0] B_CPU = 4'b0111;
    localparam logic [3:0] B_FLT = 4'b0000;
    localparam logic [3:0] B_DMA = 4'b1000;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_clock = 1'b0;
    logic [2:0] processor_status = 3'b111;
    logic       lock_n = 1'b1;
    logic       hold_request = 1'b0;
    logic       hold_acknowledge;
    logic       address_enable_n;
    logic       command_enable;
    logic       cpu_ready;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    kf_bus_arbiter #(
        .SETTLE_CYCLES   (2),
        .RELEASE_CYCLES  (1),
        .MAX_HOLD_CYCLES (MAXH)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu_clock        (cpu_clock),
        .processor_status (processor_status),
        .lock_n           (lock_n),
        .hold_request     (hold_request),
        .hold_acknowledge (hold_acknowledge),
        .address_enable_n (address_enable_n),
        .command_enable   (command_enable),
        .cpu_ready        (cpu_ready),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] bus_now();
        return {28'd0, hold_acknowledge, address_enable_n, command_enable, cpu_ready};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[tb] %-14s ok 0x%0h", tag, obs);
        end
    endtask

    // One full CPU clock period; exactly one cpu_pos event is seen by the DUT.
    task automatic cpu_cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock) cpu_clock = 1'b1;
            @(negedge clock) cpu_clock = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_value("rst_bus", bus_now(), B_CPU);
        check_value("rst_tmo", {31'd0, timeout}, 32'd0);
        @(negedge clock) reset_n = 1'b1;

        // Idle CPU handover
        hold_request = 1'b1;
        cpu_cycle(1); check_value("idle_wait", bus_now(), B_CPU);
        cpu_cycle(1); check_value("idle_aen", bus_now(), B_FLT);
        cpu_cycle(1); check_value("idle_settle", bus_now(), B_FLT);
        cpu_cycle(1); check_value("idle_grant", bus_now(), B_DMA);
        cpu_cycle(3); check_value("idle_hold", bus_now(), B_DMA);
        check_value("idle_tmo", {31'd0, timeout}, 32'd0);

        // Release, with HRQ re-raised during RELEASE
        hold_request = 1'b0;
        cpu_cycle(1); check_value("rel_hlda", bus_now(), B_FLT);
        hold_request = 1'b1;
        cpu_cycle(1); check_value("rel_idle", bus_now(), B_CPU);
        cpu_cycle(1); check_value("rel_rewait", bus_now(), B_CPU);
        cpu_cycle(1); check_value("rel_resettle", bus_now(), B_FLT);
        hold_request = 1'b0;
        cpu_cycle(1); check_value("settle_abort", bus_now(), B_FLT);
        cpu_cycle(1); check_value("settle_idle", bus_now(), B_CPU);

        // Busy CPU status holds off the handover
        processor_status = 3'b101;
        hold_request = 1'b1;
        cpu_cycle(1); check_value("busy_wait", bus_now(), B_CPU);
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(1); check_value("busy_hold", bus_now(), B_CPU);
        end
        processor_status = 3'b111;
        cpu_cycle(1); check_value("busy_aen", bus_now(), B_FLT);
        cpu_cycle(2); check_value("busy_grant", bus_now(), B_DMA);

        // Asynchronous reset in GRANT
        @(negedge clock) reset_n = 1'b0;
        #1 check_value("arst_bus", bus_now(), B_CPU);
        hold_request = 1'b0;
        @(negedge clock) reset_n = 1'b1;

        // LOCK blocks handover but never revokes a grant
        lock_n = 1'b0;
        hold_request = 1'b1;
        cpu_cycle(1); check_value("lock_wait", bus_now(), B_CPU);
        cpu_cycle(4); check_value("lock_hold", bus_now(), B_CPU);
        lock_n = 1'b1;
        cpu_cycle(1); check_value("lock_aen", bus_now(), B_FLT);
        cpu_cycle(2); check_value("lock_grant", bus_now(), B_DMA);
        lock_n = 1'b0;
        processor_status = 3'b100;
        cpu_cycle(1); check_value("lock_keep", bus_now(), B_DMA);
        hold_request = 1'b0;
        processor_status = 3'b111;
        lock_n = 1'b1;
        cpu_cycle(1); check_value("lock_rel", bus_now(), B_FLT);
        cpu_cycle(1); check_value("lock_idle", bus_now(), B_CPU);

        // HRQ pulse dropped in WAIT_IDLE, and no progress without cpu_pos
        processor_status = 3'b101;
        hold_request = 1'b1;
        cpu_cycle(1); check_value("abort_wait", bus_now(), B_CPU);
        hold_request = 1'b0;
        cpu_cycle(1); check_value("abort_idle", bus_now(), B_CPU);
        processor_status = 3'b111;
        cpu_cycle(1); check_value("abort_stay", bus_now(), B_CPU);
        hold_request = 1'b1;
        repeat (20) @(negedge clock);
        check_value("no_cpu_pos", bus_now(), B_CPU);
        cpu_cycle(1); check_value("nopos_wait", bus_now(), B_CPU);
        cpu_cycle(1); check_value("nopos_aen", bus_now(), B_FLT);
        cpu_cycle(1);
        hold_request = 1'b0;
        cpu_cycle(1); check_value("nopos_rel", bus_now(), B_FLT);
        cpu_cycle(1); check_value("nopos_idle", bus_now(), B_CPU);

`ifdef KF_BUS_ARBITER_WATCHDOG_EN
        // Watchdog: grant is cut after MAXH cpu_pos, re-arm needs HRQ low once
        hold_request = 1'b1;
        cpu_cycle(4); check_value("wd_grant", bus_now(), B_DMA);
        cpu_cycle(MAXH - 1); check_value("wd_before", bus_now(), B_DMA);
        check_value("wd_tmo_lo", {31'd0, timeout}, 32'd0);
        cpu_cycle(1); check_value("wd_cut", bus_now(), B_FLT);
        check_value("wd_tmo_hi", {31'd0, timeout}, 32'd1);
        cpu_cycle(1); check_value("wd_idle", bus_now(), B_CPU);
        cpu_cycle(2); check_value("wd_blocked", bus_now(), B_CPU);
        hold_request = 1'b0;
        cpu_cycle(1); check_value("wd_low", bus_now(), B_CPU);
        hold_request = 1'b1;
        cpu_cycle(2); check_value("wd_resettle", bus_now(), B_FLT);
        check_value("wd_tmo_keep", {31'd0, timeout}, 32'd1);
        cpu_cycle(2); check_value("wd_regrant", bus_now(), B_DMA);
        check_value("wd_tmo_clr", {31'd0, timeout}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
